jtframe_dio_seq: RTL

- Synthesizable SPI master that sequences a complete data_io ROM download from a byte source.
- Sequence: file index, TX-start, data stream, TX-end.
- Used by the MiST simulation harness and by self-loading test cores in place of the behavioural SPI transmitter.
- Drives the data_io SPI slave pins. Rate is set by a clk27 divider; the byte source feeds it through a request/valid handshake.

---
 rtl/jtframe_dio_pkg.sv | 42 ++++
 rtl/jtframe_dio_shift.sv | 67 ++++++
 rtl/jtframe_dio_seq.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/jtframe_dio_pkg.sv
// Shared definitions for the data_io download sequencer.
// Holds the data_io command bytes, the frame and FSM state encodings,
// and the helper that picks the constant/index byte for a frame position.
package jtframe_dio_pkg;

  localparam logic [7:0] DIO_FILE_TX     = 8'h53;
  localparam logic [7:0] DIO_FILE_TX_DAT = 8'h54;
  localparam logic [7:0] DIO_FILE_INDEX  = 8'h55;

  typedef enum logic [1:0] {
    F_IDX,
    F_TXON,
    F_DAT,
    F_TXOFF
  } frame_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GAP,
    ST_LOAD,
    ST_WAIT_SRC,
    ST_BIT_LO,
    ST_BIT_HI,
    ST_FRAME_END,
    ST_FIN
  } state_t;

  // Byte sent at position 0 (command) or 1 of a frame. Data bytes of
  // F_DAT come from the source, so position 1 there is never asked for.
  function automatic logic [7:0] frame_byte(frame_t f, logic second, logic [7:0] idx);
    logic [7:0] b;
    b = DIO_FILE_TX;
    case (f)
      F_IDX:   b = second ? idx : DIO_FILE_INDEX;
      F_TXON:  b = second ? 8'hFF : DIO_FILE_TX;
      F_DAT:   b = DIO_FILE_TX_DAT;
      default: b = second ? 8'h00 : DIO_FILE_TX;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/jtframe_dio_shift.sv
// Byte shifter with SCK half-period divider, MSB first, SCK idle low.
// Ports: load/din start a byte (bit7 on DI the cycle after load); sck/di
// drive the SPI pins; byte_done pulses in the cycle SCK falls after bit0.
module jtframe_dio_shift #(
  parameter int SCK_DIV = 2
) (
  input  logic       clk27,
  input  logic       rst_base,
  input  logic       load,
  input  logic [7:0] din,
  output logic       sck,
  output logic       di,
  output logic       byte_done
);

  localparam int DW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCK_DIV - 1);

  logic [6:0]    sr;
  logic [2:0]    bit_cnt;
  logic [DW-1:0] div_cnt;
  logic          active;

  always_ff @(posedge clk27 or posedge rst_base) begin
    if (rst_base) begin
      sr        <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      active    <= 1'b0;
      sck       <= 1'b0;
      di        <= 1'b0;
      byte_done <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      if (load) begin
        sr      <= din[6:0];
        di      <= din[7];
        sck     <= 1'b0;
        bit_cnt <= '0;
        div_cnt <= '0;
        active  <= 1'b1;
      end else if (active) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
          if (!sck) begin
            sck <= 1'b1;
          end else begin
            // DI only moves together with the falling SCK edge, so it is
            // stable for the whole low phase and across the next rise.
            sck <= 1'b0;
            if (bit_cnt == 3'd7) begin
              active    <= 1'b0;
              byte_done <= 1'b1;
            end else begin
              di      <= sr[6];
              sr      <= {sr[5:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end else begin
          div_cnt <= div_cnt + DW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/jtframe_dio_seq.sv
// SPI master sequencing a whole data_io download: index, TX-start, data, TX-end.
// Ports: start/index/len launch a download; byte_req/byte_valid/byte_data fetch
// data bytes; abort cuts the data frame; busy/done report progress; SPI_* pins.
module jtframe_dio_seq
  import jtframe_dio_pkg::*;
#(
  parameter int SCK_DIV = 2,
  parameter int GAP     = 4,
  parameter int LENW    = 25
) (
  input  logic            clk27,
  input  logic            rst_base,
  input  logic            start,
  input  logic [7:0]      index,
  input  logic [LENW-1:0] len,
  input  logic            abort,
  output logic            byte_req,
  input  logic            byte_valid,
  input  logic [7:0]      byte_data,
  output logic            busy,
  output logic            done,
  output logic            SPI_SCK,
  output logic            SPI_DI,
  output logic            SPI_SS2,
  output logic            SPI_SS3,
  output logic            CONF_DATA0
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  state_t          state;
  frame_t          frame;
  logic            second;     // past the command byte of the current frame
  logic [LENW-1:0] cnt;        // data bytes still to fetch
  logic [GW-1:0]   gap_cnt;
  logic [7:0]      idx_q;

  logic            fetch;
  logic            sh_load;
  logic [7:0]      sh_byte;
  logic            sh_sck;
  logic            sh_done;

  assign SPI_SS3    = 1'b1;
  assign CONF_DATA0 = 1'b1;
  assign SPI_SCK    = sh_sck;

  // Every byte after the command in F_DAT comes from the source.
  assign fetch = (frame == F_DAT) && second;

  always_comb begin
    sh_load = 1'b0;
    sh_byte = frame_byte(frame, second, idx_q);
    if (state == ST_LOAD && !fetch) begin
      sh_load = 1'b1;
    end else if (state == ST_WAIT_SRC && byte_valid) begin
      sh_load = 1'b1;
      sh_byte = byte_data;
    end
  end

  jtframe_dio_shift #(.SCK_DIV(SCK_DIV)) u_shift (
    .clk27     (clk27),
    .rst_base  (rst_base),
    .load      (sh_load),
    .din       (sh_byte),
    .sck       (sh_sck),
    .di        (SPI_DI),
    .byte_done (sh_done)
  );

  always_ff @(posedge clk27 or posedge rst_base) begin
    if (rst_base) begin
      state    <= ST_IDLE;
      frame    <= F_IDX;
      second   <= 1'b0;
      cnt      <= '0;
      gap_cnt  <= '0;
      idx_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      byte_req <= 1'b0;
      SPI_SS2  <= 1'b1;
    end else begin
      done     <= 1'b0;
      byte_req <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx_q   <= index;
            cnt     <= len;
            frame   <= F_IDX;
            second  <= 1'b0;
            gap_cnt <= '0;
            busy    <= 1'b1;
            state   <= ST_GAP;
          end
        end
        // SS2 is also high during FRAME_END and LOAD, so the high window
        // between frames is GAP cycles plus those two.
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= ST_LOAD;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        ST_LOAD: begin
          if (fetch) begin
            byte_req <= 1'b1;
            state    <= ST_WAIT_SRC;
          end else begin
            // Falls together with bit7 appearing on DI.
            SPI_SS2 <= 1'b0;
            state   <= ST_BIT_LO;
          end
        end
        ST_WAIT_SRC: begin
          if (byte_valid) begin
            cnt   <= cnt - LENW'(1);
            state <= ST_BIT_LO;
          end
        end
        ST_BIT_LO: begin
          if (sh_sck) state <= ST_BIT_HI;
        end
        ST_BIT_HI: begin
          if (sh_done) begin
            second <= 1'b1;
            if (frame == F_DAT ? (cnt == '0 || abort) : second) begin
              SPI_SS2 <= 1'b1;
              state   <= ST_FRAME_END;
            end else begin
              state <= ST_LOAD;
            end
          end else if (!sh_sck) begin
            state <= ST_BIT_LO;
          end
        end
        ST_FRAME_END: begin
          second  <= 1'b0;
          gap_cnt <= '0;
          state   <= ST_GAP;
          case (frame)
            F_IDX:   frame <= F_TXON;
            F_TXON:  frame <= (cnt == '0) ? F_TXOFF : F_DAT;
            F_DAT:   frame <= F_TXOFF;
            default: state <= ST_FIN;
          endcase
        end
        ST_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
